// File: rtl/rename_regfile_pkg.sv
// rf_pkg: shared defaults and types for the rename register file.
// Contents: default NREG/XLEN/TAG_W, ROB tag type, operand-bundle type.
package rf_pkg;
    localparam int DEF_NREG  = 32;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_IDX_W = $clog2(DEF_NREG);
    typedef logic [DEF_TAG_W-1:0] tag_t;
    typedef struct packed {
        logic [DEF_XLEN-1:0] v1;
        logic [DEF_XLEN-1:0] v2;
        tag_t                q1;
        tag_t                q2;
        logic                busy1;
        logic                busy2;
        tag_t                tag;
    } op_bundle_t;
endpackage

// File: rtl/rename_regfile_if.sv
// rename_regfile_if: dispatch, commit and operand-bundle signals of the rename register file.
// master: decoder/ROB/RS side (drives flush, disp_*, cm_*, op_ready).
// slave:  register file side (drives disp_ready, op_*).
interface rename_regfile_if
    import rf_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W
);
    localparam int IDX_W = $clog2(NREG);
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [IDX_W-1:0] disp_rs1;
    logic [IDX_W-1:0] disp_rs2;
    logic [IDX_W-1:0] disp_rd;
    logic [TAG_W-1:0] disp_tag;
    logic             cm_valid;
    logic [IDX_W-1:0] cm_rd;
    logic [TAG_W-1:0] cm_tag;
    logic [XLEN-1:0]  cm_data;
    logic             op_valid;
    logic             op_ready;
    logic [XLEN-1:0]  op_v1;
    logic [XLEN-1:0]  op_v2;
    logic [TAG_W-1:0] op_q1;
    logic [TAG_W-1:0] op_q2;
    logic             op_busy1;
    logic             op_busy2;
    logic [TAG_W-1:0] op_tag;
    modport master (
        output flush, disp_valid, disp_rs1, disp_rs2, disp_rd, disp_tag,
        output cm_valid, cm_rd, cm_tag, cm_data, op_ready,
        input  disp_ready, op_valid, op_v1, op_v2, op_q1, op_q2, op_busy1, op_busy2, op_tag
    );
    modport slave (
        input  flush, disp_valid, disp_rs1, disp_rs2, disp_rd, disp_tag,
        input  cm_valid, cm_rd, cm_tag, cm_data, op_ready,
        output disp_ready, op_valid, op_v1, op_v2, op_q1, op_q2, op_busy1, op_busy2, op_tag
    );
endinterface

// File: rtl/rename_regfile_read_port.sv
// rf_read_port: one source-operand lookup (index -> value/busy/tag) against the rename state.
// Ports: idx in; values/busys/tags register state in; cm_valid/cm_rd/cm_tag commit in;
//        v/b/q operand out. With RF_COMMIT_BYPASS_EN: cm_data in, a matching same-cycle
//        commit is forwarded. Without it: hazard out flags that same match so dispatch stalls.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [XLEN-1:0]  values [NREG],
    input  logic [NREG-1:0]  busys,
    input  logic [TAG_W-1:0] tags [NREG],
    input  logic             cm_valid,
    input  logic [IDX_W-1:0] cm_rd,
    input  logic [TAG_W-1:0] cm_tag,
`ifdef RF_COMMIT_BYPASS_EN
    input  logic [XLEN-1:0]  cm_data,
`else
    output logic             hazard,
`endif
    output logic [XLEN-1:0]  v,
    output logic             b,
    output logic [TAG_W-1:0] q
);
    logic hit;
    // the commit retiring exactly the producer this source is waiting on
    always_comb hit = cm_valid && cm_rd == idx && idx != '0 && busys[idx] && cm_tag == tags[idx];
    always_comb q = tags[idx];
`ifdef RF_COMMIT_BYPASS_EN
    always_comb v = hit ? cm_data : values[idx];
    always_comb b = busys[idx] && !hit;
`else
    always_comb v = values[idx];
    always_comb b = busys[idx];
    always_comb hazard = hit;
`endif
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with rename (busy/tag) state and a one-entry operand output register.
// Ports: clk, rst (async active-high); bus (rename_regfile_if.slave) carrying flush,
//        dispatch (disp_*), commit (cm_*) and operand bundle (op_*) signals.
// Config: RF_COMMIT_BYPASS_EN forwards a same-cycle matching commit into the operands;
//         undefined, such a dispatch stalls one cycle instead.
module rename_regfile
    import rf_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    rename_regfile_if.slave  bus
);
    localparam int IDX_W = $clog2(NREG);
    logic [XLEN-1:0]  value [NREG];
    logic [TAG_W-1:0] tag [NREG];
    logic [NREG-1:0]  busy;
    logic [XLEN-1:0]  v1, v2;
    logic [TAG_W-1:0] q1, q2;
    logic             b1, b2, fire, stall;
`ifndef RF_COMMIT_BYPASS_EN
    logic             hz1, hz2;
`endif
    rf_read_port #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W)) u_rs1 (
        .idx(bus.disp_rs1), .values(value), .busys(busy), .tags(tag),
        .cm_valid(bus.cm_valid), .cm_rd(bus.cm_rd), .cm_tag(bus.cm_tag),
`ifdef RF_COMMIT_BYPASS_EN
        .cm_data(bus.cm_data),
`else
        .hazard(hz1),
`endif
        .v(v1), .b(b1), .q(q1)
    );
    rf_read_port #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W)) u_rs2 (
        .idx(bus.disp_rs2), .values(value), .busys(busy), .tags(tag),
        .cm_valid(bus.cm_valid), .cm_rd(bus.cm_rd), .cm_tag(bus.cm_tag),
`ifdef RF_COMMIT_BYPASS_EN
        .cm_data(bus.cm_data),
`else
        .hazard(hz2),
`endif
        .v(v2), .b(b2), .q(q2)
    );
`ifdef RF_COMMIT_BYPASS_EN
    always_comb stall = 1'b0;
`else
    // without forwarding, accepting now would capture a tag that is retiring this very cycle
    always_comb stall = hz1 || hz2;
`endif
    always_comb bus.disp_ready = !bus.flush && (!bus.op_valid || bus.op_ready) && !stall;
    always_comb fire = bus.disp_valid && bus.disp_ready;
    // x0 is never written, so it keeps its reset value 0 and is never busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (bus.cm_valid && bus.cm_rd == IDX_W'(i))
                    value[i] <= bus.cm_data;
                // rename has priority over a same-cycle commit of the older producer
                if (bus.flush)
                    busy[i] <= 1'b0;
                else if (fire && bus.disp_rd == IDX_W'(i)) begin
                    busy[i] <= 1'b1;
                    tag[i]  <= bus.disp_tag;
                end else if (bus.cm_valid && bus.cm_rd == IDX_W'(i) && bus.cm_tag == tag[i])
                    busy[i] <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.op_valid <= 1'b0;
            bus.op_v1    <= '0;
            bus.op_v2    <= '0;
            bus.op_q1    <= '0;
            bus.op_q2    <= '0;
            bus.op_busy1 <= 1'b0;
            bus.op_busy2 <= 1'b0;
            bus.op_tag   <= '0;
        end else if (bus.flush)
            bus.op_valid <= 1'b0;
        else if (fire) begin
            bus.op_valid <= 1'b1;
            bus.op_v1    <= v1;
            bus.op_v2    <= v2;
            bus.op_q1    <= q1;
            bus.op_q2    <= q2;
            bus.op_busy1 <= b1;
            bus.op_busy2 <= b2;
            bus.op_tag   <= bus.disp_tag;
        end else if (bus.op_ready)
            bus.op_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed plus random checks of rename_regfile against an architectural model.
module tb_rename_regfile;
    import rf_pkg::*;
    localparam int IW = DEF_IDX_W;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rename_regfile_if bus ();
    rename_regfile dut (.clk(clk), .rst(rst), .bus(bus));
    int n_checks = 0;
    int n_errors = 0;
    logic [DEF_XLEN-1:0] m_val [DEF_NREG];
    logic                m_busy [DEF_NREG];
    tag_t                m_tag [DEF_NREG];
    op_bundle_t          m_op;
    logic                m_valid;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEF_NREG; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        m_op    = '0;
        m_valid = 1'b0;
    endtask

    function automatic logic retiring(input logic [IW-1:0] idx);
        return idx != '0 && bus.cm_valid && bus.cm_rd == idx && m_busy[idx] && m_tag[idx] == bus.cm_tag;
    endfunction

    task automatic read_src(input logic [IW-1:0] idx, output logic [DEF_XLEN-1:0] v, output tag_t q, output logic b);
        q = m_tag[idx];
        v = m_val[idx];
        b = m_busy[idx];
`ifdef RF_COMMIT_BYPASS_EN
        if (retiring(idx)) begin
            v = bus.cm_data;
            b = 1'b0;
        end
`endif
        if (idx == '0) begin
            v = '0;
            b = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("op_valid", 64'(bus.op_valid), 64'(m_valid));
        chk("op_tag", 64'(bus.op_tag), 64'(m_op.tag));
        chk("op_v1", 64'(bus.op_v1), 64'(m_op.v1));
        chk("op_v2", 64'(bus.op_v2), 64'(m_op.v2));
        chk("op_busy1", 64'(bus.op_busy1), 64'(m_op.busy1));
        chk("op_busy2", 64'(bus.op_busy2), 64'(m_op.busy2));
        if (m_op.busy1) chk("op_q1", 64'(bus.op_q1), 64'(m_op.q1));
        if (m_op.busy2) chk("op_q2", 64'(bus.op_q2), 64'(m_op.q2));
    endtask

    task automatic idle(input bit ordy = 1'b1);
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.disp_rs1   = '0;
        bus.disp_rs2   = '0;
        bus.disp_rd    = '0;
        bus.disp_tag   = '0;
        bus.cm_valid   = 1'b0;
        bus.cm_rd      = '0;
        bus.cm_tag     = '0;
        bus.cm_data    = '0;
        bus.op_ready   = ordy;
    endtask

    task automatic disp(input int rs1, input int rs2, input int rd, input int tg);
        bus.disp_valid = 1'b1;
        bus.disp_rs1   = IW'(rs1);
        bus.disp_rs2   = IW'(rs2);
        bus.disp_rd    = IW'(rd);
        bus.disp_tag   = tag_t'(tg);
    endtask

    task automatic cmt(input int rd, input int tg, input logic [DEF_XLEN-1:0] data);
        bus.cm_valid = 1'b1;
        bus.cm_rd    = IW'(rd);
        bus.cm_tag   = tag_t'(tg);
        bus.cm_data  = data;
    endtask

    // one clock: check readiness, advance the model by the architectural rules, check the bundle
    task automatic cycle();
        logic rdy, fire, stall;
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        stall = 1'b0;
`else
        stall = retiring(bus.disp_rs1) || retiring(bus.disp_rs2);
`endif
        rdy = !bus.flush && (!m_valid || bus.op_ready) && !stall;
        chk("disp_ready", 64'(bus.disp_ready), 64'(rdy));
        fire = bus.disp_valid && rdy;
        if (fire) begin
            read_src(bus.disp_rs1, m_op.v1, m_op.q1, m_op.busy1);
            read_src(bus.disp_rs2, m_op.v2, m_op.q2, m_op.busy2);
            m_op.tag = bus.disp_tag;
        end
        if (bus.cm_valid && bus.cm_rd != '0) begin
            m_val[bus.cm_rd] = bus.cm_data;
            if (m_tag[bus.cm_rd] == bus.cm_tag) m_busy[bus.cm_rd] = 1'b0;
        end
        if (fire && bus.disp_rd != '0) begin
            m_busy[bus.disp_rd] = 1'b1;
            m_tag[bus.disp_rd]  = bus.disp_tag;
        end
        if (bus.flush) for (int i = 0; i < DEF_NREG; i++) m_busy[i] = 1'b0;
        m_valid = bus.flush ? 1'b0 : fire ? 1'b1 : bus.op_ready ? 1'b0 : m_valid;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        idle(); cycle();
        // first dispatch from reset: all sources clean zero
        idle(); disp(1, 2, 3, 5); cycle();
        idle(); cycle();
        // read a renamed register, then after its commit
        idle(); disp(3, 0, 0, 1); cycle();
        idle(); cmt(3, 5, 32'h1234); cycle();
        idle(); disp(3, 3, 3, 6); cycle();
        idle(); cmt(3, 6, 32'h77); cycle();
        // stale commit must not clear a newer rename
        idle(); disp(0, 0, 4, 2); cycle();
        idle(); disp(0, 0, 4, 7); cycle();
        idle(); cmt(4, 2, 32'hAA); cycle();
        idle(); disp(4, 4, 0, 8); cycle();
        // same-cycle commit and dispatch reading the producer
        idle(); disp(0, 0, 6, 3); cycle();
        idle(); disp(6, 1, 0, 9); cmt(6, 3, 32'h55); cycle();
        idle(); disp(6, 1, 0, 9); cycle();
        // commit and rename of the same rd in one cycle
        idle(); disp(0, 0, 5, 4); cycle();
        idle(); disp(0, 0, 5, 11); cmt(5, 4, 32'h99); cycle();
        idle(); disp(5, 0, 0, 12); cycle();
        // backpressure for three cycles, then flush
        idle(0); disp(1, 2, 7, 9); cycle();
        repeat (3) begin idle(0); disp(2, 3, 5, 1); cycle(); end
        idle(0); disp(2, 3, 5, 1); bus.flush = 1'b1; cmt(2, 0, 32'hBEEF); cycle();
        idle(); disp(7, 5, 0, 2); cycle();
        idle(); disp(2, 4, 0, 3); cycle();
        // x0 stays zero
        idle(); disp(0, 0, 0, 1); cmt(0, 0, 32'hFFFF); cycle();
        idle(); disp(0, 0, 0, 2); cycle();
        // random traffic over a few registers for frequent collisions
        for (int n = 0; n < 500; n++) begin
            int crd;
            idle($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                disp($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0) begin
                crd = $urandom_range(0, 7);
                cmt(crd, $urandom_range(0, 2) != 0 ? int'(m_tag[crd]) : $urandom_range(0, 15), $urandom);
            end
            bus.flush = $urandom_range(0, 29) == 0;
            cycle();
        end
        // asynchronous reset with a bundle held
        idle(0); disp(1, 2, 3, 4); cycle();
        idle(0); rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        #3;
        rst = 1'b0;
        idle(); cycle();
        idle(); disp(3, 4, 0, 1); cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 Parameters: NREG, default 32, architectural register count (power of 2, x0 hardwired zero).
REQ-002 Parameters: XLEN, default 32, data width; TAG_W, default 4, ROB tag width; IDX_W = clog2(NREG).
REQ-003 Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- flush  in  1  exception/mispredict; discard all renaming
- disp_valid  in  1  decoder presents instruction
- disp_ready  out  1  block accepts instruction this cycle
- disp_rs1, disp_rs2, disp_rd  in  IDX_W each  source/destination indices
- disp_tag  in  TAG_W  ROB tag allocated to instruction
- cm_valid  in  1  ROB commit strobe
- cm_rd  in  IDX_W  committed destination
- cm_tag  in  TAG_W  committed ROB tag
- cm_data  in  XLEN  committed value
- op_valid  out  1  operand bundle valid
- op_ready  in  1  RS/SLB accepts bundle
- op_v1, op_v2  out  XLEN each  source values
- op_q1, op_q2  out  TAG_W each  producer tags
- op_busy1, op_busy2  out  1 each  operand pending; op_q meaningful only when set
- op_tag  out  TAG_W  passthrough of disp_tag

Function
REQ-004 Per-register state: value[XLEN], busy bit, tag[TAG_W]; x0 value always 0, never busy.
REQ-005 disp_ready = !op_valid || op_ready (one-entry output register), forced 0 while flush is high.
REQ-006 Dispatch fires on disp_valid && disp_ready; bundle registered, appears with op_valid=1 next cycle (latency 1).
REQ-007 Operands read pre-rename state: rs == rd of the same instruction returns the older producer.
REQ-008 On fire with disp_rd != 0: busy[rd] <= 1, tag[rd] <= disp_tag.
REQ-009 Commit with cm_rd != 0: value[cm_rd] <= cm_data always; busy cleared only if tag[cm_rd] == cm_tag.
REQ-010 Commit and dispatch to same rd in one cycle: dispatch rename wins (busy stays 1, new tag).
REQ-011 op_valid clears when op_ready && !fire; holds bundle stable while op_valid && !op_ready.
REQ-012 Flush: all busy <= 0, op_valid <= 0, no dispatch accepted; same-cycle commit still writes value.
REQ-013 Commit with cm_rd == 0 ignored entirely.

Reset
REQ-014 On rst: all values 0, all busy 0, all tags 0; op_valid 0, op_v*/op_q*/op_busy*/op_tag 0; disp_ready 1 after rst deasserts.
REQ-015 Reset mid-operation discards pending bundle; no output toggles until first post-reset fire.

Configuration
REQ-016 Macro RF_COMMIT_BYPASS_EN defined: at fire, a source with busy set and matching same-cycle commit (cm_valid, cm_rd == rs, cm_tag == tag[rs]) outputs op_v = cm_data, op_busy = 0.
REQ-017 Macro undefined: disp_ready additionally forced 0 when cm_valid and cm_rd equals a busy, non-zero disp_rs1 or disp_rs2 with matching tag (one-cycle stall; never an orphaned tag).

Structure
REQ-018 Shared package rf_pkg: XLEN, TAG_W, NREG defaults, tag typedef, operand-bundle typedef.
REQ-019 One sub-module rf_read_port (index -> value/busy/tag with optional bypass), instantiated twice.

Verification
REQ-020 Reset, dispatch rs1=1, rs2=2, rd=3, tag=5 -> next cycle op_valid=1, v1=v2=0, busy1=busy2=0; busy[3]=1 tag 5.
REQ-021 Dispatch rd=3 tag=5, then rs1=3 -> op_busy1=1, op_q1=5; commit rd=3 tag=5 data=0x1234, then rs1=3 -> v1=0x1234, busy1=0.
REQ-022 Rename x4 tag 2 then tag 7; commit x4 tag 2 -> busy[4] stays 1 with tag 7, value updated.
REQ-023 Same-cycle commit x6 tag 3 and dispatch rs1=6: with RF_COMMIT_BYPASS_EN -> v1=cm_data, busy1=0, no stall; without -> disp_ready=0 one cycle, then v1=cm_data.
REQ-024 op_ready=0 for 3 cycles with op_valid=1 -> bundle constant, disp_ready=0; flush mid-stall -> op_valid=0 next cycle, all busy cleared.
REQ-025 Dispatch rd=0 and commit rd=0 data=0xFFFF -> reading x0 returns 0, busy 0.
